periph_bridge: RTL and testbench

Parametrised CPU-to-peripheral bridge for the P7 MIPS core, between the M stage and the data memory, timer-class peripherals and the interrupt generator. It decodes N_DEV device windows, routes word writes, and returns read data aligned with the synchronous data memory. It also contains an interrupt controller (synchroniser, per-line edge/level mode, pending and mask registers) and a sticky bus-error capture.

---
 rtl/bridge_pkg.sv | 44 ++++
 rtl/irq_ctrl.sv | 68 ++++++
 rtl/periph_bridge.sv | 167 ++++++++++++++++
 tb/tb_periph_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared constants for the CPU-to-peripheral bridge: default
//                address map, control-block offsets, interrupt vector width
//                and read-source select encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

   localparam int HWINT_W = 6;

   localparam logic [31:0] DEF_DEV_BASE   = 32'h0000_7f00;
   localparam logic [31:0] DEF_DEV_STRIDE = 32'h0000_0010;
   localparam logic [31:0] DEF_DEV_SIZE   = 32'h0000_000c;
   localparam logic [31:0] DEF_INT_BASE   = 32'h0000_7f20;
   localparam logic [31:0] DEF_CTRL_BASE  = 32'h0000_7f30;
   localparam logic [HWINT_W-1:0] DEF_EDGE_MASK = 6'b000100;

   // Byte offsets inside the control block
   localparam logic [3:0] CTRL_PEND    = 4'h0;
   localparam logic [3:0] CTRL_MASK    = 4'h4;
   localparam logic [3:0] CTRL_ACK     = 4'h8;
   localparam logic [3:0] CTRL_ERRADDR = 4'hc;

   // Source of the registered read data returned to the W stage
   typedef enum logic [2:0] {
      SEL_DM   = 3'd0,
      SEL_DEV0 = 3'd1,
      SEL_DEV1 = 3'd2,
      SEL_DEV2 = 3'd3,
      SEL_DEV3 = 3'd4,
      SEL_DEV4 = 3'd5,
      SEL_CTRL = 3'd6,
      SEL_ZERO = 3'd7
   } rd_sel_e;

   // Select code for device window idx (0..4)
   function automatic rd_sel_e dev_sel(input int idx);
      return rd_sel_e'(3'(idx + 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Interrupt controller: 2-flop synchroniser for external lines,
//                per-bit edge/level pending capture, ACK clear, mask register
//                and masked HWInt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
   import bridge_pkg::*;
#(
   parameter int                 N_DEV     = 2,
   parameter int                 N_EXT     = 1,
   parameter logic [HWINT_W-1:0] EDGE_MASK = DEF_EDGE_MASK
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_DEV-1:0]   dev_irq,
   input  logic [N_EXT-1:0]   ext_irq,
   input  logic               mask_we,
   input  logic               ack_we,
   input  logic [HWINT_W-1:0] wdata,
   output logic [HWINT_W-1:0] pending,
   output logic [HWINT_W-1:0] mask,
   output logic [HWINT_W-1:0] hwint
);

   logic [N_EXT-1:0]   sync1_d, sync1_q, sync2_d, sync2_q;
   logic [HWINT_W-1:0] raw, ack_clr;
   logic [HWINT_W-1:0] prev_d, prev_q, pend_d, pend_q, mask_d, mask_q;

   // Raw vector and next state; an edge arriving with ACK keeps its bit set
   always_comb begin
      raw                      = '0;
      raw[N_DEV-1:0]           = dev_irq;
      raw[N_DEV+N_EXT-1:N_DEV] = sync2_q;
      sync1_d = ext_irq;
      sync2_d = sync1_q;
      prev_d  = raw;
      ack_clr = ack_we ? wdata : '0;
      pend_d  = (EDGE_MASK & ((raw & ~prev_q) | (pend_q & ~ack_clr)))
              | (~EDGE_MASK & raw);
      mask_d  = mask_we ? wdata : mask_q;
   end

   // State registers; reset discards pending and reopens every line
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
      end
   end

   assign pending = pend_q;
   assign mask    = mask_q;
   assign hwint   = pend_q & mask_q;

endmodule
`default_nettype wire

// File: rtl/periph_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : periph_bridge
//  Description : M-stage bridge between the CPU, data memory, N_DEV device
//                windows and the interrupt generator. Decodes the bridge
//                region, routes word writes, returns 1-cycle read data and
//                captures bus errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_bridge
   import bridge_pkg::*;
#(
   parameter int                 N_DEV      = 2,
   parameter int                 N_EXT      = 1,
   parameter logic [31:0]        DEV_BASE   = DEF_DEV_BASE,
   parameter logic [31:0]        DEV_STRIDE = DEF_DEV_STRIDE,
   parameter logic [31:0]        DEV_SIZE   = DEF_DEV_SIZE,
   parameter logic [31:0]        INT_BASE   = DEF_INT_BASE,
   parameter logic [31:0]        CTRL_BASE  = DEF_CTRL_BASE,
   parameter logic [HWINT_W-1:0] EDGE_MASK  = DEF_EDGE_MASK
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          m_data_addr_in,
   input  logic [31:0]          m_data_wdata_in,
   input  logic [3:0]           m_data_byteen_in,
   input  logic                 m_data_re,
   input  logic [31:0]          m_data_rdata,
   output logic [31:0]          m_data_rdata_out,
   output logic [31:0]          m_data_addr,
   output logic [31:0]          m_data_wdata,
   output logic [3:0]           m_data_byteen,
   output logic [31:0]          dev_addr,
   output logic [31:0]          dev_wdata,
   output logic [N_DEV-1:0]     dev_we,
   input  logic [32*N_DEV-1:0]  dev_rdata,
   input  logic [N_DEV-1:0]     dev_irq,
   input  logic [N_EXT-1:0]     ext_irq,
   output logic [31:0]          m_int_addr,
   output logic [3:0]           m_int_byteen,
   output logic [HWINT_W-1:0]   HWInt,
   output logic                 bus_err
);

   logic [N_DEV-1:0]   dev_hit;
   logic [31:0]        int_off, ctrl_off;
   logic [3:0]         ctrl_byte;
   logic               int_hit, ctrl_hit, in_region, access;
   logic               full_wr, part_wr, bus_error;
   logic               ctrl_wr, mask_we, ack_we, eclr_we;
   rd_sel_e            rd_sel_d, rd_sel_q;
   logic [31:0]        rdata_d, rdata_q, erraddr_d, erraddr_q;
   logic               bus_err_d, bus_err_q;
   logic [HWINT_W-1:0] pending, mask;

   // Per-device window decode and full-word write enable
   for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev_dec
      localparam logic [31:0] BASE = DEV_BASE + DEV_STRIDE * 32'(gi);
      logic [31:0] off;
      assign off          = m_data_addr_in - BASE;
      assign dev_hit[gi]  = (m_data_addr_in >= BASE) && (off < DEV_SIZE);
      assign dev_we[gi]   = dev_hit[gi] && full_wr;
   end

   // Region decode, error classification and control-register write strobes
   always_comb begin
      int_off   = m_data_addr_in - INT_BASE;
      ctrl_off  = m_data_addr_in - CTRL_BASE;
      int_hit   = (m_data_addr_in >= INT_BASE) && (int_off < 32'd4);
      ctrl_hit  = (m_data_addr_in >= CTRL_BASE) && (ctrl_off < 32'd16);
      ctrl_byte = {ctrl_off[3:2], 2'b00};
      in_region = (m_data_addr_in >= DEV_BASE) && (m_data_addr_in <= CTRL_BASE + 32'd15);
      access    = m_data_re || (m_data_byteen_in != 4'h0);
      full_wr   = (m_data_byteen_in == 4'hf);
      part_wr   = (m_data_byteen_in != 4'h0) && !full_wr;
      bus_error = in_region && access &&
                  (!((|dev_hit) || int_hit || ctrl_hit) || (((|dev_hit) || ctrl_hit) && part_wr));
      ctrl_wr   = ctrl_hit && full_wr;
      mask_we   = ctrl_wr && (ctrl_byte == CTRL_MASK);
      ack_we    = ctrl_wr && (ctrl_byte == CTRL_ACK);
      eclr_we   = ctrl_wr && (ctrl_byte == CTRL_ERRADDR);
   end

   assign m_data_addr   = m_data_addr_in;
   assign m_data_wdata  = m_data_wdata_in;
   assign m_data_byteen = in_region ? 4'h0 : m_data_byteen_in;
   assign dev_addr      = m_data_addr_in;
   assign dev_wdata     = m_data_wdata_in;
   assign m_int_addr    = int_hit ? m_data_addr_in : 32'h0;
   assign m_int_byteen  = int_hit ? m_data_byteen_in : 4'h0;

   // Read source select and registered device/control data; idle cycles return 0
   always_comb begin
      rd_sel_d = SEL_ZERO;
      rdata_d  = '0;
      if (m_data_re) begin
         if (!in_region) begin
            rd_sel_d = SEL_DM;
         end else if (ctrl_hit) begin
            rd_sel_d = SEL_CTRL;
            case (ctrl_byte)
               CTRL_PEND:    rdata_d = {{(32-HWINT_W){1'b0}}, pending};
               CTRL_MASK:    rdata_d = {{(32-HWINT_W){1'b0}}, mask};
               CTRL_ERRADDR: rdata_d = erraddr_q;
               default:      rdata_d = '0;
            endcase
         end else begin
            for (int i = 0; i < N_DEV; i++) begin
               if (dev_hit[i]) begin
                  rd_sel_d = dev_sel(i);
                  rdata_d  = dev_rdata[32*i +: 32];
               end
            end
         end
      end
   end

   // Sticky error capture; a new error outranks a same-cycle clear
   always_comb begin
      bus_err_d = bus_err_q;
      erraddr_d = erraddr_q;
      if (bus_error) begin
         bus_err_d = 1'b1;
         erraddr_d = m_data_addr_in;
      end else if (eclr_we) begin
         bus_err_d = 1'b0;
      end
   end

   // Bridge state registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_sel_q  <= SEL_ZERO;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         erraddr_q <= '0;
      end else begin
         rd_sel_q  <= rd_sel_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         erraddr_q <= erraddr_d;
      end
   end

   // DM data arrives one cycle after its address, so it passes through live
   assign m_data_rdata_out = (rd_sel_q == SEL_DM) ? m_data_rdata : rdata_q;
   assign bus_err          = bus_err_q;

   irq_ctrl #(
      .N_DEV     (N_DEV),
      .N_EXT     (N_EXT),
      .EDGE_MASK (EDGE_MASK)
   ) u_irq (
      .clk     (clk),
      .reset   (reset),
      .dev_irq (dev_irq),
      .ext_irq (ext_irq),
      .mask_we (mask_we),
      .ack_we  (ack_we),
      .wdata   (m_data_wdata_in[HWINT_W-1:0]),
      .pending (pending),
      .mask    (mask),
      .hwint   (HWInt)
   );

endmodule
`default_nettype wire

// File: tb/tb_periph_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_periph_bridge
//  Description : Scoreboard bench for periph_bridge: default build plus a
//                4-device build sharing the CPU-side stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bridge;

   localparam int K_RD = 0, K_HW = 1, K_ERR = 2, K_WE = 3, K_DMBE = 4, K_INTBE = 5;
   localparam int K_RD4 = 6, K_WE4 = 7, K_ERR4 = 8;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   logic         clk, reset;
   logic [31:0]  addr_in, wdata_in, dm_rdata;
   logic [3:0]   be_in;
   logic         re_in;
   logic [0:0]   ext_irq;
   logic [63:0]  dev_rdata2;
   logic [1:0]   dev_irq2;
   logic [127:0] dev_rdata4;
   logic [3:0]   dev_irq4;

   logic [31:0] rdata_out2, dm_addr2, dm_wdata2, dev_addr2, dev_wdata2, int_addr2;
   logic [3:0]  dm_be2, int_be2;
   logic [1:0]  dev_we2;
   logic [5:0]  hwint2;
   logic        bus_err2;

   logic [31:0] rdata_out4, dm_addr4, dm_wdata4, dev_addr4, dev_wdata4, int_addr4;
   logic [3:0]  dm_be4, int_be4;
   logic [3:0]  dev_we4;
   logic [5:0]  hwint4;
   logic        bus_err4;

   periph_bridge u_dut (
      .clk(clk), .reset(reset),
      .m_data_addr_in(addr_in), .m_data_wdata_in(wdata_in), .m_data_byteen_in(be_in),
      .m_data_re(re_in), .m_data_rdata(dm_rdata), .m_data_rdata_out(rdata_out2),
      .m_data_addr(dm_addr2), .m_data_wdata(dm_wdata2), .m_data_byteen(dm_be2),
      .dev_addr(dev_addr2), .dev_wdata(dev_wdata2), .dev_we(dev_we2),
      .dev_rdata(dev_rdata2), .dev_irq(dev_irq2), .ext_irq(ext_irq),
      .m_int_addr(int_addr2), .m_int_byteen(int_be2), .HWInt(hwint2), .bus_err(bus_err2)
   );

   periph_bridge #(
      .N_DEV(4), .N_EXT(1), .INT_BASE(32'h7f40), .CTRL_BASE(32'h7f50)
   ) u_dut4 (
      .clk(clk), .reset(reset),
      .m_data_addr_in(addr_in), .m_data_wdata_in(wdata_in), .m_data_byteen_in(be_in),
      .m_data_re(re_in), .m_data_rdata(dm_rdata), .m_data_rdata_out(rdata_out4),
      .m_data_addr(dm_addr4), .m_data_wdata(dm_wdata4), .m_data_byteen(dm_be4),
      .dev_addr(dev_addr4), .dev_wdata(dev_wdata4), .dev_we(dev_we4),
      .dev_rdata(dev_rdata4), .dev_irq(dev_irq4), .ext_irq(ext_irq),
      .m_int_addr(int_addr4), .m_int_byteen(int_be4), .HWInt(hwint4), .bus_err(bus_err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         K_RD:    return rdata_out2;
         K_HW:    return {26'b0, hwint2};
         K_ERR:   return {31'b0, bus_err2};
         K_WE:    return {30'b0, dev_we2};
         K_DMBE:  return {28'b0, dm_be2};
         K_INTBE: return {28'b0, int_be2};
         K_RD4:   return rdata_out4;
         K_WE4:   return {28'b0, dev_we4};
         K_ERR4:  return {31'b0, bus_err4};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: compare every expectation that falls due in this cycle
   always @(negedge clk) begin
      logic [31:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act    = actual(sb[i].kind);
            checks = checks + 1;
            if (act !== sb[i].val) begin
               errors = errors + 1;
               $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].nm, act, sb[i].val, cyc);
            end
            sb.delete(i);
         end
      end
   end

   function automatic void exp_at(input int d, input int kind, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc + d;
      e.kind = kind;
      e.val  = v;
      e.nm   = nm;
      sb.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr_in  = 32'h0;
      wdata_in = 32'h0;
      be_in    = 4'h0;
      re_in    = 1'b0;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input logic re);
      addr_in  = a;
      wdata_in = wd;
      be_in    = be;
      re_in    = re;
   endtask

   initial begin
      reset      = 1'b0;
      idle();
      dm_rdata   = 32'h0;
      ext_irq    = 1'b0;
      dev_rdata2 = {32'h0000_1234, 32'h0000_5555};
      dev_irq2   = 2'b00;
      dev_rdata4 = {32'h0000_a003, 32'h0000_a002, 32'h0000_a001, 32'h0000_a000};
      dev_irq4   = 4'b0000;
      repeat (3) step();

      exp_at(0, K_RD,  32'h0, "reset_rdata");
      exp_at(0, K_HW,  32'h0, "reset_hwint");
      exp_at(0, K_ERR, 32'h0, "reset_bus_err");
      reset = 1'b1;
      step();

      // Reads: device 1, device 0, data memory pass-through
      drive(32'h7f14, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h1234, "dev1_read"); step(); idle();
      drive(32'h7f04, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h5555, "dev0_read"); step(); idle();
      drive(32'h0100, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'hcafe_0100, "dm_read"); step(); idle();
      dm_rdata = 32'hcafe_0100; step(); dm_rdata = 32'h0;

      // Writes: device word, DM, interrupt generator
      drive(32'h7f08, 32'hdead, 4'hf, 1'b0);
      exp_at(0, K_WE, 32'h1, "sw_dev0_we");
      exp_at(0, K_DMBE, 32'h0, "sw_dev0_dm_be");
      exp_at(1, K_WE, 32'h0, "sw_dev0_we_one_cycle");
      exp_at(1, K_ERR, 32'h0, "sw_dev0_no_err");
      #1;
      checks = checks + 1;
      if (dev_addr2 !== 32'h7f08) begin
         errors = errors + 1;
         $display("FAIL dev_addr_pass: got %h expected %h", dev_addr2, 32'h7f08);
      end
      checks = checks + 1;
      if (dev_wdata2 !== 32'hdead) begin
         errors = errors + 1;
         $display("FAIL dev_wdata_pass: got %h expected %h", dev_wdata2, 32'hdead);
      end
      step(); idle();
      drive(32'h0200, 32'h1, 4'hf, 1'b0);
      exp_at(0, K_DMBE, 32'hf, "sw_dm_be"); exp_at(0, K_WE, 32'h0, "sw_dm_no_dev_we");
      #1;
      checks = checks + 1;
      if (dm_addr2 !== 32'h0200) begin
         errors = errors + 1;
         $display("FAIL dm_addr_pass: got %h expected %h", dm_addr2, 32'h0200);
      end
      checks = checks + 1;
      if (dm_wdata2 !== 32'h1) begin
         errors = errors + 1;
         $display("FAIL dm_wdata_pass: got %h expected %h", dm_wdata2, 32'h1);
      end
      step(); idle();
      drive(32'h7f20, 32'h1, 4'hf, 1'b0);
      exp_at(0, K_INTBE, 32'hf, "sw_int_be"); exp_at(0, K_DMBE, 32'h0, "sw_int_dm_be");
      #1;
      checks = checks + 1;
      if (int_addr2 !== 32'h7f20) begin
         errors = errors + 1;
         $display("FAIL int_addr_hit: got %h expected %h", int_addr2, 32'h7f20);
      end
      step(); idle();

      // Partial device write and error capture
      drive(32'h7f10, 32'hbeef, 4'h3, 1'b0);
      exp_at(0, K_WE, 32'h0, "sh_dev1_suppressed"); exp_at(1, K_ERR, 32'h1, "sh_dev1_err");
      step(); idle();
      drive(32'h7f3c, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h7f10, "erraddr_sh"); step(); idle();
      drive(32'h7f3c, 0, 4'hf, 1'b0); exp_at(1, K_ERR, 32'h0, "err_clear"); step(); idle();

      // Unmapped accesses
      drive(32'h7f1c, 0, 4'h0, 1'b1); exp_at(1, K_ERR, 32'h1, "unmapped_load_err"); step(); idle();
      drive(32'h7f3c, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h7f1c, "erraddr_unmapped"); step(); idle();
      drive(32'h7f28, 0, 4'h0, 1'b1); step(); idle();
      drive(32'h7f3c, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h7f28, "erraddr_7f28"); step(); idle();
      drive(32'h7f3c, 0, 4'h3, 1'b0); exp_at(1, K_ERR, 32'h1, "err_beats_clear"); step(); idle();
      drive(32'h7f3c, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h7f3c, "erraddr_partial_ctrl"); step(); idle();

      // External edge interrupt through the synchroniser
      ext_irq = 1'b1;
      exp_at(2, K_HW, 32'h0, "ext_sync_delay");
      exp_at(3, K_HW, 32'h4, "ext_edge_pending");
      exp_at(5, K_HW, 32'h4, "ext_edge_held");
      step(); ext_irq = 1'b0;
      repeat (5) step();
      drive(32'h7f38, 32'h4, 4'hf, 1'b0); exp_at(1, K_HW, 32'h0, "ack_clears"); step(); idle();
      ext_irq = 1'b1; step(); ext_irq = 1'b0; step();
      drive(32'h7f38, 32'h4, 4'hf, 1'b0); exp_at(1, K_HW, 32'h4, "edge_beats_ack"); step(); idle();
      drive(32'h7f38, 32'h4, 4'hf, 1'b0); exp_at(1, K_HW, 32'h0, "ack_again"); step(); idle();

      // Level interrupt and mask
      dev_irq2 = 2'b01; exp_at(1, K_HW, 32'h1, "level_dev0"); step();
      drive(32'h7f34, 32'h3e, 4'hf, 1'b0); exp_at(1, K_HW, 32'h0, "mask_hides"); step(); idle();
      drive(32'h7f30, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h1, "pend_while_masked"); step(); idle();
      drive(32'h7f34, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h3e, "mask_readback"); step(); idle();
      dev_irq2 = 2'b00; step();
      drive(32'h7f30, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h0, "pend_level_drop"); step(); idle();

      // Reset in the middle of a read with an interrupt pending
      ext_irq = 1'b1; step(); ext_irq = 1'b0;
      repeat (3) step();
      exp_at(0, K_HW, 32'h4, "pre_reset_pending");
      exp_at(0, K_ERR, 32'h1, "pre_reset_err");
      reset = 1'b0;
      drive(32'h7f14, 0, 4'h0, 1'b1);
      exp_at(1, K_RD, 32'h0, "reset_flushes_read");
      exp_at(1, K_HW, 32'h0, "reset_drops_pending");
      exp_at(1, K_ERR, 32'h0, "reset_clears_err");
      step(); reset = 1'b1; idle();
      drive(32'h7f34, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h3f, "reset_mask_reload"); step(); idle();
      drive(32'h7f3c, 0, 4'h0, 1'b1); exp_at(1, K_RD, 32'h0, "reset_erraddr"); step(); idle();

      // Four-device build: every window, moved control block, gap error
      drive(32'h7f5c, 0, 4'hf, 1'b0); exp_at(1, K_ERR4, 32'h0, "dut4_err_clear"); step(); idle();
      for (int i = 0; i < 4; i++) begin
         drive(32'h7f00 + 32'(16 * i), 0, 4'h0, 1'b1);
         exp_at(1, K_RD4, 32'ha000 + 32'(i), $sformatf("dut4_read_dev%0d", i));
         step(); idle();
      end
      for (int i = 0; i < 4; i++) begin
         drive(32'h7f08 + 32'(16 * i), 32'(i), 4'hf, 1'b0);
         exp_at(0, K_WE4, 32'(1 << i), $sformatf("dut4_we_dev%0d", i));
         step(); idle();
      end
      drive(32'h7f54, 0, 4'h0, 1'b1); exp_at(1, K_RD4, 32'h3f, "dut4_ctrl_mask"); step(); idle();
      drive(32'h7f2c, 0, 4'h0, 1'b1); exp_at(1, K_ERR4, 32'h1, "dut4_gap_err"); step(); idle();

      repeat (4) step();
      foreach (sb[i]) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: never checked, due cycle %0d", sb[i].nm, sb[i].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
